// File: rtl/kernel_fetch.sv
// -----------------------------------------------------------------------------
// kernel_fetch
// Read sequencer between the kernel memory and the convolution group. It loads
// the memory read pointer with a configured start address, pops a window of
// (len+1) words, repeats the window (rpt+1) times and presents the words as a
// valid/ready stream. The memory's one-cycle pop-to-data latency is hidden by
// a 2-entry output buffer plus a single in-flight flag.
//
// Optional feature: define KERNEL_FETCH_ABORT_EN to add the 'abort' input,
// which flushes the fetcher back to IDLE from any busy state.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start/len/rpt   window start address, words-1, passes-1
//   cfg_val / cfg_rdy   configuration handshake (cfg_rdy high only in IDLE)
//   mem_rd_addr(_set)   memory read-pointer load
//   mem_rd_data(_pop)   memory read data (valid the cycle after a pop) / pop
//   ker_data/val/rdy    output stream, ker_last marks the last word of a pass
//   done                one-cycle pulse after the final word is consumed
//   abort               (KERNEL_FETCH_ABORT_EN only) flush to IDLE
// -----------------------------------------------------------------------------
module kernel_fetch #(
  parameter int GROUP_NB   = 4,
  parameter int KER_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int RPT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef KERNEL_FETCH_ABORT_EN
  input  logic                          abort,
`endif
  input  logic [MEM_AWIDTH-1:0]         cfg_start,
  input  logic [MEM_AWIDTH-1:0]         cfg_len,
  input  logic [RPT_WIDTH-1:0]          cfg_rpt,
  input  logic                          cfg_val,
  output logic                          cfg_rdy,
  output logic [MEM_AWIDTH-1:0]         mem_rd_addr,
  output logic                          mem_rd_addr_set,
  input  logic [GROUP_NB*KER_WIDTH-1:0] mem_rd_data,
  output logic                          mem_rd_data_pop,
  output logic [GROUP_NB*KER_WIDTH-1:0] ker_data,
  output logic                          ker_val,
  input  logic                          ker_rdy,
  output logic                          ker_last,
  output logic                          done
);

  localparam int DW = GROUP_NB * KER_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [MEM_AWIDTH-1:0] start_q, start_d;
  logic [MEM_AWIDTH-1:0] len_q, len_d;
  logic [RPT_WIDTH-1:0]  rpt_q, rpt_d;
  logic [MEM_AWIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [RPT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;
  // Buffer entry 0 is always the head; entry 1 is valid only when entry 0 is.
  logic                  val0_q, val0_d, val1_q, val1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [DW-1:0]         data0_q, data0_d, data1_q, data1_d;
  logic                  done_q, done_d;

  logic                  abort_s;
  logic                  hs_s;
  logic [1:0]            occ_s;
  logic                  room_s;
  logic                  pop_s;
  logic                  tag_s;

`ifdef KERNEL_FETCH_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign hs_s   = val0_q & ker_rdy;
  // Words held or owed: buffered entries plus the word the memory is returning.
  assign occ_s  = 2'(val0_q) + 2'(val1_q) + 2'(infl_q);
  // A word leaving this cycle frees a slot for a word popped this cycle.
  assign room_s = (occ_s - 2'(hs_s)) < 2'd2;
  assign pop_s  = (state_q == STREAM) && room_s && !abort_s;
  assign tag_s  = (word_cnt_q == len_q);

  assign cfg_rdy         = (state_q == IDLE);
  assign mem_rd_addr_set = (state_q == LOAD);
  assign mem_rd_addr     = start_q;
  assign mem_rd_data_pop = pop_s;
  assign ker_data        = data0_q;
  assign ker_val         = val0_q;
  assign ker_last        = last0_q;
  assign done            = done_q;

  // Next-state, counters, in-flight tracking and output buffer update.
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    len_d       = len_q;
    rpt_d       = rpt_q;
    word_cnt_d  = word_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    val0_d      = val0_q;
    val1_d      = val1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    done_d      = 1'b0;
    infl_d      = pop_s;
    infl_last_d = 1'b0;

    if (pop_s) begin
      infl_last_d = tag_s;
    end else begin
      infl_last_d = 1'b0;
    end

    // Head leaves on a handshake; the second entry moves up.
    if (hs_s) begin
      data0_d = data1_q;
      last0_d = last1_q;
      val0_d  = val1_q;
      val1_d  = 1'b0;
    end else begin
      val1_d  = val1_q;
    end

    // Returning memory word lands in the first free slot after the shift.
    if (infl_q) begin
      if (!val0_d) begin
        data0_d = mem_rd_data;
        last0_d = infl_last_q;
        val0_d  = 1'b1;
      end else begin
        data1_d = mem_rd_data;
        last1_d = infl_last_q;
        val1_d  = 1'b1;
      end
    end else begin
      data1_d = data1_d;
    end

    case (state_q)
      IDLE: begin
        if (cfg_val) begin
          start_d    = cfg_start;
          len_d      = cfg_len;
          rpt_d      = cfg_rpt;
          word_cnt_d = '0;
          pass_cnt_d = '0;
          state_d    = LOAD;
        end else begin
          state_d    = IDLE;
        end
      end
      LOAD: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (pop_s) begin
          word_cnt_d = word_cnt_q + MEM_AWIDTH'(1);
          if (tag_s) begin
            if (pass_cnt_q != rpt_q) begin
              pass_cnt_d = pass_cnt_q + RPT_WIDTH'(1);
              word_cnt_d = '0;
              state_d    = LOAD;
            end else begin
              state_d    = DRAIN;
            end
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        // Finish when the buffer empties at the end of this cycle, so done and
        // cfg_rdy appear together right after the final handshake.
        if (!val0_d && !infl_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_s && (state_q != IDLE)) begin
      state_d = IDLE;
      val0_d  = 1'b0;
      val1_d  = 1'b0;
      infl_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      done_d  = done_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= '0;
      len_q       <= '0;
      rpt_q       <= '0;
      word_cnt_q  <= '0;
      pass_cnt_q  <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      val0_q      <= 1'b0;
      val1_q      <= 1'b0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      len_q       <= len_d;
      rpt_q       <= rpt_d;
      word_cnt_q  <= word_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      val0_q      <= val0_d;
      val1_q      <= val1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_kernel_fetch.sv
// -----------------------------------------------------------------------------
// tb_kernel_fetch
// Directed bench for kernel_fetch with a behavioural kernel memory whose word
// at address a is a fixed function of a. Handshakes, pops and done pulses are
// recorded on the falling edge; each test then compares the recorded stream
// against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_kernel_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_start = 16'h0000;
  logic [15:0] cfg_len = 16'h0000;
  logic [7:0]  cfg_rpt = 8'h00;
  logic        cfg_val = 1'b0;
  logic        cfg_rdy;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_addr_set;
  logic [63:0] mem_rd_data;
  logic        mem_rd_data_pop;
  logic [63:0] ker_data;
  logic        ker_val;
  logic        ker_rdy = 1'b1;
  logic        ker_last;
  logic        done;
`ifdef KERNEL_FETCH_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  kernel_fetch dut (
    .clk             (clk),
    .rst             (rst),
`ifdef KERNEL_FETCH_ABORT_EN
    .abort           (abort),
`endif
    .cfg_start       (cfg_start),
    .cfg_len         (cfg_len),
    .cfg_rpt         (cfg_rpt),
    .cfg_val         (cfg_val),
    .cfg_rdy         (cfg_rdy),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_addr_set (mem_rd_addr_set),
    .mem_rd_data     (mem_rd_data),
    .mem_rd_data_pop (mem_rd_data_pop),
    .ker_data        (ker_data),
    .ker_val         (ker_val),
    .ker_rdy         (ker_rdy),
    .ker_last        (ker_last),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5A5, a + 16'h1111, ~a, a};
  endfunction

  // Kernel memory: pointer load, pop returns data one cycle later.
  logic [15:0] mem_ptr = 16'h0000;
  logic [63:0] mem_q = 64'h0;
  assign mem_rd_data = mem_q;
  always @(posedge clk) begin
    if (mem_rd_addr_set) mem_ptr <= mem_rd_addr;
    else if (mem_rd_data_pop) mem_ptr <= mem_ptr + 16'd1;
    if (mem_rd_data_pop) mem_q <= mem_word(mem_ptr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Recorder (owned by the monitor process only).
  logic [63:0] got_d[$];
  bit          got_l[$];
  int          got_c[$];
  int          acc_cyc = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0;
  int          pop_cnt = 0, hs_cnt = 0, max_lead = 0;
  int          hold_seen = 0, hold_bad = 0;
  bit          done_rdy = 1'b0;

  initial begin : monitor
    bit          stall_prev;
    logic [63:0] prev_data;
    bit          prev_last;
    stall_prev = 1'b0;
    prev_data  = 64'h0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (cfg_val && cfg_rdy) begin acc_cyc = cyc; acc_cnt++; end
        if (ker_val && ker_rdy) begin
          got_d.push_back(ker_data);
          got_l.push_back(ker_last);
          got_c.push_back(cyc);
          hs_cnt++;
        end
        if (mem_rd_data_pop) pop_cnt++;
        if (pop_cnt - hs_cnt > max_lead) max_lead = pop_cnt - hs_cnt;
        if (done) begin done_cnt++; done_cyc = cyc; done_rdy = cfg_rdy; end
        if (stall_prev) begin
          hold_seen++;
          if (!ker_val || ker_data !== prev_data || ker_last !== prev_last) hold_bad++;
        end
        stall_prev = ker_val && !ker_rdy;
        prev_data  = ker_data;
        prev_last  = ker_last;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_stream(input int base, input logic [15:0] s, input logic [15:0] l,
                              input logic [7:0] r);
    int n, w;
    logic [15:0] a;
    n = (int'(l) + 1) * (int'(r) + 1);
    check("word_count", 64'(got_d.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < got_d.size()) begin
        w = i % (int'(l) + 1);
        a = s + 16'(w);
        check("word_data", got_d[base+i], mem_word(a));
        check("word_last", 64'(got_l[base+i]), 64'(w == int'(l)));
      end
    end
  endtask

  int last_base = 0;

  // mode 0: ker_rdy high; 1: 5-cycle stall after word 2 then toggle; 2: busy cfg poke
  task automatic run_cfg(input logic [15:0] s, input logic [15:0] l, input logic [7:0] r,
                         input int mode);
    int base, dbase, abase, stall;
    bit phase, seen;
    base  = got_d.size();
    dbase = done_cnt;
    abase = acc_cnt;
    @(posedge clk); #1;
    cfg_start = s; cfg_len = l; cfg_rpt = r; cfg_val = 1'b1;
    @(posedge clk); #1;
    cfg_val = 1'b0;
    seen = 1'b0; stall = 0; phase = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      if (mode == 1) begin
        if (!phase && (got_d.size() - base >= 2)) begin phase = 1'b1; stall = 5; end
        if (stall > 0) begin ker_rdy = 1'b0; stall--; end
        else if (phase) ker_rdy = ~ker_rdy;
        else ker_rdy = 1'b1;
      end else if (mode == 2) begin
        cfg_start = 16'h0100;
        cfg_val   = (i == 2);
      end
    end
    ker_rdy = 1'b1;
    cfg_val = 1'b0;
    @(negedge clk); #1;
    check("done_seen", 64'(seen), 64'd1);
    check("done_once", 64'(done_cnt - dbase), 64'd1);
    check("cfg_once", 64'(acc_cnt - abase), 64'd1);
    check_stream(base, s, l, r);
    last_base = base;
  endtask

  initial begin : main
    int base, dbase;
    bit seen;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    check("rst_ker_val", 64'(ker_val), 64'd0);
    check("rst_ker_last", 64'(ker_last), 64'd0);
    check("rst_ker_data", ker_data, 64'd0);
    check("rst_addr_set", 64'(mem_rd_addr_set), 64'd0);
    check("rst_pop", 64'(mem_rd_data_pop), 64'd0);
    check("rst_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Basic window: latency T+4, 4 back-to-back words, done right after last
    run_cfg(16'h0010, 16'd3, 8'd0, 0);
    if (got_c.size() >= last_base + 4) begin
      check("first_lat", 64'(got_c[last_base] - acc_cyc), 64'd4);
      check("last_lat", 64'(got_c[last_base+3] - acc_cyc), 64'd7);
    end
    check("done_lat", 64'(done_cyc - acc_cyc), 64'd8);
    check("done_cfg_rdy", 64'(done_rdy), 64'd1);

    // Repeats: one bubble per rewind
    run_cfg(16'h0020, 16'd1, 8'd2, 0);
    if (got_c.size() >= last_base + 6) begin
      for (int i = 1; i < 6; i++)
        check("rpt_gap", 64'(got_c[last_base+i] - got_c[last_base+i-1]), (i % 2 == 0) ? 64'd2 : 64'd1);
    end

    // Backpressure
    run_cfg(16'h0200, 16'd7, 8'd0, 1);
    check("hold_stable", 64'(hold_bad), 64'd0);
    check("hold_seen", 64'(hold_seen >= 5), 64'd1);
    check("pop_lead_max", 64'(max_lead), 64'd2);

    // Wrap with a busy cfg poke, then minimum window
    run_cfg(16'hFFFE, 16'd3, 8'd0, 2);
    run_cfg(16'h0300, 16'd0, 8'd0, 0);

    // Reset mid-stream
    base  = got_d.size();
    dbase = done_cnt;
    @(posedge clk); #1;
    cfg_start = 16'h0050; cfg_len = 16'd7; cfg_rpt = 8'd0; cfg_val = 1'b1;
    @(posedge clk); #1;
    cfg_val = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (got_d.size() - base >= 3) seen = 1'b1;
    end
    check("rst_reach3", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_val", 64'(ker_val), 64'd0);
    check("mid_rst_rdy", 64'(cfg_rdy), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk); #1;
    check("mid_rst_nodone", 64'(done_cnt - dbase), 64'd0);
    run_cfg(16'h0060, 16'd2, 8'd1, 0);

`ifdef KERNEL_FETCH_ABORT_EN
    // Abort with two words held
    dbase = done_cnt;
    ker_rdy = 1'b0;
    @(posedge clk); #1;
    cfg_start = 16'h0070; cfg_len = 16'd7; cfg_rpt = 8'd0; cfg_val = 1'b1;
    @(posedge clk); #1;
    cfg_val = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_held", 64'(ker_val), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ker_rdy = 1'b1;
    check("abort_val", 64'(ker_val), 64'd0);
    check("abort_rdy", 64'(cfg_rdy), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk); #1;
    check("abort_nodone", 64'(done_cnt - dbase), 64'd0);
    run_cfg(16'h0040, 16'd1, 8'd0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kernel_fetch.md
# kernel_fetch

Read sequencer that sits directly downstream of the kernel memory: it drives the memory's read-address load, read-pop and read-data lines, and replays a configured window of kernel words, optionally repeated, as a valid/ready stream into the convolution group. It hides the memory's one-cycle pop-to-data latency with a 2-entry output buffer. It sustains one word per cycle under full downstream readiness, and it inserts one bubble per pass rewind.

## Interface
- GROUP_NB, 4, kernels per group; data word is GROUP_NB*KER_WIDTH bits
- KER_WIDTH, 16, bits per kernel value
- MEM_AWIDTH, 16, kernel memory address width
- RPT_WIDTH, 8, width of repeat count
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- cfg_start  in  MEM_AWIDTH  first word address of a pass
- cfg_len  in  MEM_AWIDTH  words per pass minus one
- cfg_rpt  in  RPT_WIDTH  passes minus one
- cfg_val  in  1  configuration valid
- cfg_rdy  out  1  high only in IDLE; cfg accepted on cfg_val & cfg_rdy
- mem_rd_addr  out  MEM_AWIDTH  read address to memory (= latched start)
- mem_rd_addr_set  out  1  load memory read pointer
- mem_rd_data  in  GROUP_NB*KER_WIDTH  memory read data, valid the cycle after a pop
- mem_rd_data_pop  out  1  read memory and advance its pointer
- ker_data  out  GROUP_NB*KER_WIDTH  output word (buffer head)
- ker_val  out  1  output valid
- ker_rdy  in  1  downstream ready
- ker_last  out  1  head word is the last of its pass
- done  out  1  one-cycle pulse when the final word of the final pass is consumed

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE: cfg_rdy=1. On acceptance, latch start, len, and rpt. Clear the word counter and pass counter. Go to LOAD.
- LOAD: mem_rd_addr_set=1 with mem_rd_addr=start. Pop is 0 in this state, because the memory drops the pointer increment when set and pop coincide. Go to STREAM.
- STREAM: assert pop when (buffer count + in-flight − (ker_val & ker_rdy)) < 2.
  - Each pop increments the word counter.
  - Each pop carries a last tag, set when word counter == len.
- On a tagged pop: if pass counter != rpt, increment it, clear the word counter, and go to LOAD. Otherwise go to DRAIN.
- DRAIN: no pops. When the buffer is empty and nothing is in flight, pulse done and go to IDLE.
- In-flight word: a 1-bit flag plus its last tag. It is written into the buffer tail on the cycle after the pop, from mem_rd_data.
- Buffer: 2-entry FIFO of {data, last}. The head drives ker_data/ker_last. ker_val = count != 0.
- Address wrap is the memory's modulo-2^MEM_AWIDTH pointer. The fetcher counts words, never compares addresses.
- Total words emitted per configuration = (cfg_len+1)*(cfg_rpt+1).
- cfg_val outside IDLE is ignored.

## Timing
- Reset values: cfg_rdy=1, ker_val=0, ker_last=0, ker_data=0, mem_rd_addr_set=0, mem_rd_data_pop=0, mem_rd_addr=0, done=0. FSM is in IDLE and the buffer is empty.
- Reset mid-operation: next cycle is IDLE with the buffer empty and no done pulse.
- Accept at cycle T:
  - T+1: LOAD.
  - T+2: first pop.
  - T+3: mem_rd_data valid and captured.
  - T+4: ker_val=1.
- With ker_rdy held high: one word per cycle within a pass, plus one bubble per LOAD.
- With ker_rdy low: ker_data and ker_last are held stable. At most 2 words are held (buffered + in flight), and no word is lost.
- done: asserted in the cycle after the final handshake; cfg_rdy rises in the same cycle.
- Simultaneous push and pop on the buffer is legal at any occupancy.

## Configuration
- KERNEL_FETCH_ABORT_EN defined: adds input port abort (1 bit).
  - When abort=1 in any state, the next cycle is IDLE with the buffer and in-flight flag flushed, ker_val=0, and no done pulse.
  - abort is ignored in IDLE; rst has priority over abort.
- Not defined: the port is absent, and a configuration always runs to completion or to reset.

## Test plan
- Basic window: start=0x0010, len=3, rpt=0, ker_rdy=1.
  - mem[0x10..0x13] is emitted on consecutive cycles from T+4.
  - ker_last is high on the 4th word only; done pulses once; cfg_rdy returns high.
- Repeats: start=0x0020, len=1, rpt=2.
  - Output sequence is m20, m21, m20, m21, m20, m21.
  - ker_last is high on words 2, 4 and 6; exactly one bubble between passes; 6 handshakes total.
- Backpressure: len=7; drop ker_rdy for 5 cycles after word 2, and toggle it every cycle afterwards.
  - All 8 words arrive in order and are stable while stalled.
  - Pops never exceed handshakes by more than 2.
- Wrap and minimum:
  - start=0xFFFE, len=3: words from addresses FFFE, FFFF, 0000, 0001.
  - len=0, rpt=0: single word with ker_last=1 and done.
  - cfg_val pulsed while busy is ignored.
- Reset mid-stream: assert rst after word 3 of 8.
  - Next cycle: ker_val=0, cfg_rdy=1, done=0.
  - A new config afterwards streams correctly.
- Abort (KERNEL_FETCH_ABORT_EN): abort during STREAM with 2 words held.
  - Next cycle: ker_val=0, cfg_rdy=1, no done.
  - A following config start=0x0040, len=1 yields m40, m41 only.
